y86_mem_responder: RTL and testbench

Byte-addressed main-memory model that answers the Y86-64 pipeline's instruction-fetch and data-access requests. It is the responder end of the `imem_ok`/`dmem_ok` interface. Two independent ports share one byte array:
- an instruction port returning a 10-byte (80-bit) fetch window;
- a data port doing 8-byte little-endian reads and writes.

Each port has a programmable fixed latency, an `ok` pulse, and an address-error flag feeding the pipeline's ADR status.

---
 rtl/y86_mem_pkg.sv | 17 +
 rtl/y86_mem_port_fsm.sv | 75 +++++++
 rtl/y86_mem_responder.sv | 150 +++++++++++++++
 tb/tb_y86_mem_responder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// Shared widths, byte counts and per-port state encoding for the Y86-64 memory responder.
package y86_mem_pkg;

    localparam int MEM_DATA_WIDTH = 64;
    localparam int MEM_ADDR_WIDTH = 64;
    localparam int PC_WIDTH       = 80;

    localparam int DATA_BYTES  = 8;
    localparam int INSTR_BYTES = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } port_state_e;

endpackage

// File: rtl/y86_mem_port_fsm.sv
// Per-port request sequencer: accepts a request in IDLE, waits a fixed latency,
// strobes the access on the last wait edge and raises ok for one cycle.
module y86_mem_port_fsm
    import y86_mem_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    output logic o_capture,
    output logic o_exec,
    output logic o_ok
);

    port_state_e r_state;
    port_state_e w_next;
    logic [3:0]  r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (o_capture) begin
                r_cnt <= 4'(LATENCY - 1);
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // With LATENCY=1 the access executes on the acceptance edge, so BUSY is skipped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_req) begin
                    w_next = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == 4'd1) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Reset suppresses the execute strobe so an in-flight write never lands.
    always_comb begin
        o_capture = 1'b0;
        o_exec    = 1'b0;
        o_ok      = 1'b0;
        case (r_state)
            IDLE: begin
                o_capture = i_req;
                o_exec    = i_req && (LATENCY == 1) && !i_rst;
            end
            BUSY: begin
                o_exec = (r_cnt == 4'd1) && !i_rst;
            end
            DONE: begin
                o_ok = 1'b1;
            end
            default: begin
                o_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/y86_mem_responder.sv
// Byte-addressed memory model serving a 10-byte instruction fetch port and an
// 8-byte little-endian data port, each with fixed latency and address checking.
module y86_mem_responder
    import y86_mem_pkg::*;
#(
    parameter int    MEM_BYTES      = 8192,
    parameter int    MEM_DATA_WIDTH = y86_mem_pkg::MEM_DATA_WIDTH,
    parameter int    MEM_ADDR_WIDTH = y86_mem_pkg::MEM_ADDR_WIDTH,
    parameter int    PC_WIDTH       = y86_mem_pkg::PC_WIDTH,
    parameter int    LATENCY        = 2,
    parameter string INIT_FILE      = ""
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MEM_ADDR_WIDTH-1:0] iaddr,
    input  logic                      i_req,
    output logic [PC_WIDTH-1:0]       instr,
    output logic                      i_ok,
    output logic                      i_err,
    input  logic [MEM_ADDR_WIDTH-1:0] maddr,
    input  logic                      renable,
    input  logic                      wenable,
    input  logic [MEM_DATA_WIDTH-1:0] wdata,
    output logic [MEM_DATA_WIDTH-1:0] rdata,
    output logic                      m_ok,
    output logic                      m_err
);

    localparam int IDX_W = $clog2(MEM_BYTES);

    // True when the span [a, a+last] leaves the array; the extra bit catches 64-bit wrap.
    function automatic logic span_bad(input logic [MEM_ADDR_WIDTH-1:0] a, input int unsigned last);
        logic [MEM_ADDR_WIDTH:0] v_end;
        v_end = {1'b0, a} + (MEM_ADDR_WIDTH + 1)'(last);
        return v_end >= (MEM_ADDR_WIDTH + 1)'(MEM_BYTES);
    endfunction

    logic w_i_cap, w_i_exec, w_i_ok;
    logic w_m_cap, w_m_exec, w_m_ok;

    y86_mem_port_fsm #(.LATENCY(LATENCY)) u_ifsm (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (i_req),
        .o_capture (w_i_cap),
        .o_exec    (w_i_exec),
        .o_ok      (w_i_ok)
    );

    y86_mem_port_fsm #(.LATENCY(LATENCY)) u_mfsm (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (renable | wenable),
        .o_capture (w_m_cap),
        .o_exec    (w_m_exec),
        .o_ok      (w_m_ok)
    );

    logic [MEM_ADDR_WIDTH-1:0] r_iaddr;
    logic [MEM_ADDR_WIDTH-1:0] r_maddr;
    logic                      r_rd;
    logic                      r_wr;
    logic [MEM_DATA_WIDTH-1:0] r_wdata;

    always_ff @(posedge clk) begin
        if (w_i_cap) begin
            r_iaddr <= iaddr;
        end
        if (w_m_cap) begin
            r_maddr <= maddr;
            r_rd    <= renable;
            r_wr    <= wenable;
            r_wdata <= wdata;
        end
    end

    // Capture and execute coincide only when LATENCY=1; then the live inputs are used.
    logic [MEM_ADDR_WIDTH-1:0] w_iaddr;
    logic [MEM_ADDR_WIDTH-1:0] w_maddr;
    logic                      w_rd;
    logic                      w_wr;
    logic [MEM_DATA_WIDTH-1:0] w_wdata;
    logic                      w_i_bad;
    logic                      w_m_bad;
    logic [IDX_W-1:0]          w_i_idx;
    logic [IDX_W-1:0]          w_m_idx;
    logic                      w_do_write;

    assign w_iaddr    = w_i_cap ? iaddr   : r_iaddr;
    assign w_maddr    = w_m_cap ? maddr   : r_maddr;
    assign w_rd       = w_m_cap ? renable : r_rd;
    assign w_wr       = w_m_cap ? wenable : r_wr;
    assign w_wdata    = w_m_cap ? wdata   : r_wdata;
    assign w_i_bad    = span_bad(w_iaddr, INSTR_BYTES - 1);
    assign w_m_bad    = span_bad(w_maddr, DATA_BYTES - 1) || (w_rd && w_wr);
    assign w_i_idx    = w_iaddr[IDX_W-1:0];
    assign w_m_idx    = w_maddr[IDX_W-1:0];
    assign w_do_write = w_m_exec && w_wr && !w_m_bad;

    logic [7:0] r_mem [MEM_BYTES];

    // Array contents survive reset; only the write strobe is reset-qualified.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int k = 0; k < DATA_BYTES; k++) begin
                r_mem[w_m_idx + IDX_W'(k)] <= w_wdata[8*k +: 8];
            end
        end
    end

    logic [PC_WIDTH-1:0]       r_instr;
    logic                      r_i_err;
    logic [MEM_DATA_WIDTH-1:0] r_rdata;
    logic                      r_m_err;

    // Reads sample the array before this edge's write lands, giving pre-write fetch data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= '0;
            r_i_err <= 1'b0;
            r_rdata <= '0;
            r_m_err <= 1'b0;
        end else begin
            if (w_i_exec) begin
                r_i_err <= w_i_bad;
                for (int k = 0; k < INSTR_BYTES; k++) begin
                    r_instr[8*k +: 8] <= w_i_bad ? 8'h00 : r_mem[w_i_idx + IDX_W'(k)];
                end
            end
            if (w_m_exec) begin
                r_m_err <= w_m_bad;
                if (w_m_bad) begin
                    r_rdata <= '0;
                end else if (w_rd) begin
                    for (int k = 0; k < DATA_BYTES; k++) begin
                        r_rdata[8*k +: 8] <= r_mem[w_m_idx + IDX_W'(k)];
                    end
                end
            end
        end
    end

    assign instr = r_instr;
    assign i_ok  = w_i_ok;
    assign i_err = r_i_err;
    assign rdata = r_rdata;
    assign m_ok  = w_m_ok;
    assign m_err = r_m_err;

endmodule

// File: tb/tb_y86_mem_responder.sv
// Scoreboard bench for y86_mem_responder: a LATENCY=2 instance for the main
// scenarios and a LATENCY=1 instance for single-cycle timing and same-edge conflicts.
`timescale 1ns/1ps
module tb_y86_mem_responder;

    localparam int MB = 8192;

    typedef struct {
        logic        err;
        logic [79:0] val;
        logic [79:0] mask;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] a_iaddr, a_maddr, a_wdata, a_rdata;
    logic        a_ireq, a_ren, a_wen, a_iok, a_ierr, a_mok, a_merr;
    logic [79:0] a_instr;
    logic [63:0] b_iaddr, b_maddr, b_wdata, b_rdata;
    logic        b_ireq, b_ren, b_wen, b_iok, b_ierr, b_mok, b_merr;
    logic [79:0] b_instr;

    y86_mem_responder #(.LATENCY(2)) dut_a (
        .clk(clk), .rst(rst),
        .iaddr(a_iaddr), .i_req(a_ireq), .instr(a_instr), .i_ok(a_iok), .i_err(a_ierr),
        .maddr(a_maddr), .renable(a_ren), .wenable(a_wen), .wdata(a_wdata),
        .rdata(a_rdata), .m_ok(a_mok), .m_err(a_merr)
    );

    y86_mem_responder #(.LATENCY(1)) dut_b (
        .clk(clk), .rst(rst),
        .iaddr(b_iaddr), .i_req(b_ireq), .instr(b_instr), .i_ok(b_iok), .i_err(b_ierr),
        .maddr(b_maddr), .renable(b_ren), .wenable(b_wen), .wdata(b_wdata),
        .rdata(b_rdata), .m_ok(b_mok), .m_err(b_merr)
    );

    logic [7:0] mdl [MB];
    exp_t q_m[$];
    exp_t q_i[$];
    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic data_access(input string name, input logic rd, input logic wr,
                               input logic [63:0] addr, input logic [63:0] wd);
        exp_t e;
        exp_t got;
        int   cyc;
        e.err  = (rd && wr) || (addr > 64'(MB - 8));
        e.val  = '0;
        e.mask = '0;
        if (e.err) begin
            e.mask = {16'h0, {64{1'b1}}};
        end else if (rd) begin
            e.mask = {16'h0, {64{1'b1}}};
            for (int k = 0; k < 8; k++) e.val[8*k +: 8] = mdl[int'(addr) + k];
        end
        q_m.push_back(e);
        a_maddr = addr; a_ren = rd; a_wen = wr; a_wdata = wd;
        tick();
        a_ren = 1'b0; a_wen = 1'b0; a_maddr = '1; a_wdata = '1;
        cyc = 1;
        while (a_mok !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        got = q_m.pop_front();
        checks++;
        if (a_mok !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: m_ok=%b after %0d cycles, required 1", name, a_mok, cyc);
        end else begin
            checks++;
            if (cyc !== 2) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles, required 2", name, cyc);
            end
            checks++;
            if (a_merr !== got.err) begin
                errors++;
                $display("FAIL %s m_err: got %b, required %b", name, a_merr, got.err);
            end
            if (got.mask != '0) begin
                checks++;
                if (({16'h0, a_rdata} & got.mask) !== (got.val & got.mask)) begin
                    errors++;
                    $display("FAIL %s rdata: got %h, required %h", name, a_rdata, got.val[63:0]);
                end
            end
            tick();
            checks++;
            if (a_mok !== 1'b0) begin
                errors++;
                $display("FAIL %s m_ok pulse: got %b one cycle later, required 0", name, a_mok);
            end
        end
        if (wr && !e.err) begin
            for (int k = 0; k < 8; k++) mdl[int'(addr) + k] = wd[8*k +: 8];
        end
    endtask

    task automatic fetch_access(input string name, input logic [63:0] addr, input logic [79:0] mask);
        exp_t e;
        exp_t got;
        int   cyc;
        e.err  = addr > 64'(MB - 10);
        e.val  = '0;
        e.mask = e.err ? {80{1'b1}} : mask;
        if (!e.err) begin
            for (int k = 0; k < 10; k++) e.val[8*k +: 8] = mdl[int'(addr) + k];
        end
        q_i.push_back(e);
        a_iaddr = addr; a_ireq = 1'b1;
        tick();
        a_ireq = 1'b0; a_iaddr = '0;
        cyc = 1;
        while (a_iok !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        got = q_i.pop_front();
        checks++;
        if (a_iok !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: i_ok=%b after %0d cycles, required 1", name, a_iok, cyc);
        end else begin
            checks++;
            if (cyc !== 2) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles, required 2", name, cyc);
            end
            checks++;
            if (a_ierr !== got.err) begin
                errors++;
                $display("FAIL %s i_err: got %b, required %b", name, a_ierr, got.err);
            end
            checks++;
            if ((a_instr & got.mask) !== (got.val & got.mask)) begin
                errors++;
                $display("FAIL %s instr: got %h, required %h (mask %h)", name, a_instr, got.val, got.mask);
            end
            tick();
            checks++;
            if (a_iok !== 1'b0) begin
                errors++;
                $display("FAIL %s i_ok pulse: got %b one cycle later, required 0", name, a_iok);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({a_iok, a_mok, a_ierr, a_merr} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags_a: got %b, required 0000", {a_iok, a_mok, a_ierr, a_merr});
        end
        checks++;
        if (a_instr !== 80'h0) begin
            errors++;
            $display("FAIL reset_instr_a: got %h, required 0", a_instr);
        end
        checks++;
        if (a_rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata_a: got %h, required 0", a_rdata);
        end
        checks++;
        if ({b_iok, b_mok, b_ierr, b_merr, b_instr, b_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_b: got ok=%b%b err=%b%b instr=%h rdata=%h, required all 0",
                     b_iok, b_mok, b_ierr, b_merr, b_instr, b_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        data_access("write_100", 1'b0, 1'b1, 64'h100, 64'h1122334455667788);
        data_access("read_100", 1'b1, 1'b0, 64'h100, 64'h0);
        checks++;
        if (a_rdata !== 64'h1122334455667788 || a_rdata[7:0] !== 8'h88) begin
            errors++;
            $display("FAIL read_100_const: got %h, required 1122334455667788", a_rdata);
        end
    endtask

    task automatic test_fetch();
        fetch_access("fetch_103", 64'h103, {40'h0, {40{1'b1}}});
        checks++;
        if (a_instr[39:0] !== 40'h1122334455) begin
            errors++;
            $display("FAIL fetch_103_const: got %h, required 1122334455", a_instr[39:0]);
        end
    endtask

    task automatic test_boundary();
        data_access("write_end16", 1'b0, 1'b1, 64'(MB - 16), 64'hA1A2A3A4A5A6A7A8);
        data_access("write_end8", 1'b0, 1'b1, 64'(MB - 8), 64'hB1B2B3B4B5B6B7B8);
        data_access("read_end8", 1'b1, 1'b0, 64'(MB - 8), 64'h0);
        data_access("read_end7", 1'b1, 1'b0, 64'(MB - 7), 64'h0);
        fetch_access("fetch_end10", 64'(MB - 10), {80{1'b1}});
        fetch_access("fetch_end9", 64'(MB - 9), {80{1'b1}});
        data_access("write_wrap", 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'hDEADBEEFCAFEF00D);
        data_access("read_end8_after_wrap", 1'b1, 1'b0, 64'(MB - 8), 64'h0);
    endtask

    task automatic test_both_enables();
        data_access("both_enables", 1'b1, 1'b1, 64'h100, 64'h0BADC0DE0BADC0DE);
        data_access("read_100_after_both", 1'b1, 1'b0, 64'h100, 64'h0);
    endtask

    task automatic test_back_to_back();
        int okc[$];
        int exp_c[4] = '{2, 5, 8, 11};
        a_maddr = 64'h100; a_ren = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (a_mok === 1'b1) begin
                okc.push_back(c);
                checks++;
                if (a_rdata !== 64'h1122334455667788) begin
                    errors++;
                    $display("FAIL b2b_rdata cycle %0d: got %h, required 1122334455667788", c, a_rdata);
                end
            end
        end
        a_ren = 1'b0;
        checks++;
        if (okc.size() !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d ok pulses, required 4", okc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (okc[i] !== exp_c[i]) begin
                    errors++;
                    $display("FAIL b2b_cycle %0d: got %0d, required %0d", i, okc[i], exp_c[i]);
                end
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_concurrent();
        int m_first = -1;
        int i_first = -1;
        int m_cnt = 0;
        int i_cnt = 0;
        a_maddr = 64'h100; a_ren = 1'b1;
        tick();
        a_ren = 1'b0; a_iaddr = 64'h103; a_ireq = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) a_ireq = 1'b0;
            if (a_mok === 1'b1) begin
                m_cnt++;
                if (m_first < 0) m_first = c;
            end
            if (a_iok === 1'b1) begin
                i_cnt++;
                if (i_first < 0) i_first = c;
            end
            tick();
        end
        checks++;
        if (m_first !== 2 || m_cnt !== 1) begin
            errors++;
            $display("FAIL concurrent_m: first ok cycle %0d count %0d, required 2 and 1", m_first, m_cnt);
        end
        checks++;
        if (i_first !== 3 || i_cnt !== 1) begin
            errors++;
            $display("FAIL concurrent_i: first ok cycle %0d count %0d, required 3 and 1", i_first, i_cnt);
        end
        checks++;
        if (a_instr[39:0] !== 40'h1122334455) begin
            errors++;
            $display("FAIL concurrent_instr: got %h, required 1122334455", a_instr[39:0]);
        end
    endtask

    task automatic test_reset_midwrite();
        int seen = 0;
        data_access("write_200_old", 1'b0, 1'b1, 64'h200, 64'h0102030405060708);
        data_access("read_200_old", 1'b1, 1'b0, 64'h200, 64'h0);
        a_maddr = 64'h200; a_wen = 1'b1; a_wdata = 64'hFFEEDDCCBBAA9988;
        tick();
        a_wen = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({a_iok, a_mok, a_ierr, a_merr, a_instr, a_rdata} !== '0) begin
            errors++;
            $display("FAIL midwrite_reset_outputs: ok=%b%b err=%b%b instr=%h rdata=%h, required all 0",
                     a_iok, a_mok, a_ierr, a_merr, a_instr, a_rdata);
        end
        for (int c = 0; c < 4; c++) begin
            if (a_mok === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midwrite_no_ok: got %0d m_ok pulses, required 0", seen);
        end
        data_access("read_200_after_reset", 1'b1, 1'b0, 64'h200, 64'h0);
    endtask

    task automatic test_latency1();
        exp_t e;
        exp_t got;
        b_maddr = 64'h300; b_wen = 1'b1; b_wdata = 64'h8877665544332211;
        e.err = 1'b0; e.val = 80'h0; e.mask = '0;
        q_m.push_back(e);
        tick();
        b_wen = 1'b0;
        got = q_m.pop_front();
        checks++;
        if (b_mok !== 1'b1 || b_merr !== got.err) begin
            errors++;
            $display("FAIL lat1_write: m_ok=%b m_err=%b, required 1 and %b", b_mok, b_merr, got.err);
        end
        tick();
        checks++;
        if (b_mok !== 1'b0) begin
            errors++;
            $display("FAIL lat1_pulse: m_ok=%b, required 0", b_mok);
        end
        b_maddr = 64'h300; b_wen = 1'b1; b_wdata = 64'h0FEDCBA987654321;
        b_iaddr = 64'h300; b_ireq = 1'b1;
        e.err = 1'b0; e.val = {16'h0, 64'h8877665544332211}; e.mask = {16'h0, {64{1'b1}}};
        q_i.push_back(e);
        tick();
        b_wen = 1'b0; b_ireq = 1'b0;
        got = q_i.pop_front();
        checks++;
        if (b_iok !== 1'b1 || b_mok !== 1'b1 || b_ierr !== got.err) begin
            errors++;
            $display("FAIL lat1_same_edge_ok: i_ok=%b m_ok=%b i_err=%b, required 1 1 %b", b_iok, b_mok, b_ierr, got.err);
        end
        checks++;
        if ((b_instr & got.mask) !== (got.val & got.mask)) begin
            errors++;
            $display("FAIL lat1_same_edge_instr: got %h, required %h", b_instr[63:0], got.val[63:0]);
        end
        tick();
        b_maddr = 64'h300; b_ren = 1'b1;
        e.err = 1'b0; e.val = {16'h0, 64'h0FEDCBA987654321}; e.mask = {16'h0, {64{1'b1}}};
        q_m.push_back(e);
        tick();
        b_ren = 1'b0;
        got = q_m.pop_front();
        checks++;
        if (b_mok !== 1'b1 || b_merr !== got.err || ({16'h0, b_rdata} & got.mask) !== got.val) begin
            errors++;
            $display("FAIL lat1_read: m_ok=%b m_err=%b rdata=%h, required 1 %b %h", b_mok, b_merr, b_rdata, got.err, got.val[63:0]);
        end
        tick();
    endtask

    initial begin
        rst = 1'b0;
        a_iaddr = '0; a_ireq = 1'b0; a_maddr = '0; a_ren = 1'b0; a_wen = 1'b0; a_wdata = '0;
        b_iaddr = '0; b_ireq = 1'b0; b_maddr = '0; b_ren = 1'b0; b_wen = 1'b0; b_wdata = '0;
        tick();
        test_reset();
        test_write_read();
        test_fetch();
        test_boundary();
        test_both_enables();
        test_back_to_back();
        test_concurrent();
        test_reset_midwrite();
        test_latency1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

endmodule
